synchronizer_debouncer: RTL
===========================

// Module: synchronizer_debouncer
// PURPOSE
//  Multi-channel CDC synchronizer for asynchronous inputs (buttons, switches, external strobes).
//  Each channel has a configurable-depth flop chain, an optional per-channel debounce filter,
//  and registered-source rising/falling edge pulses.
//  Sits between the FPGA pins and any logic in the Clock domain. It replaces per-signal 2-flop chains.
// PARAMETERS
//  WIDTH            4        number of independent channels (>=1)
//  STAGES           2        synchronizer flop depth (>=2)
//  DEBOUNCE_CYCLES  4        consecutive stable cycles required before Sync_o changes (>=1; debounce build only)
//  RESET_VALUE      {WIDTH{1'b0}}  value loaded into every stage, Sync_o and edge history at reset
// PORTS
//  Clock    in   1      system clock; all state on rising edge
//  Reset    in   1      synchronous, active-high reset
//  Async_i  in   WIDTH  asynchronous inputs; no timing relation to Clock
//  Sync_o   out  WIDTH  synchronized (and optionally debounced) level
//  Rise_o   out  WIDTH  1-cycle pulse per channel when Sync_o goes 0->1
//  Fall_o   out  WIDTH  1-cycle pulse per channel when Sync_o goes 1->0
// BEHAVIOUR
//  - Reset:
//    - On an edge with Reset=1, all chain stages, Sync_o, the previous-Sync_o register and the debounce counters
//      are loaded. Stages, Sync_o and previous-Sync_o load RESET_VALUE; counters load 0.
//    - Rise_o and Fall_o are 0 during reset and in the first cycle after it.
//    - Reset has priority over all other updates. Reset mid-debounce discards the pending change and emits no pulse.
//  - Chain:
//    - Async_i feeds stage 1 only. Nothing else samples Async_i.
//    - Stage n+1 <= stage n on each edge. s = stage STAGES.
//    - Channels are fully independent. There is no bus coherency: bits changing together may land on different cycles.
//  - Latency without debounce:
//    - Sync_o = s.
//    - An input stable before capture edge k is visible on Sync_o after edge k+STAGES-1, i.e. STAGES edges.
//  - Edges:
//    - Sync_prev <= Sync_o on each edge.
//    - Rise_o = Sync_o & ~Sync_prev and Fall_o = ~Sync_o & Sync_prev.
//    - Both are decoded from registers only, with no Async_i path. Each pulse lasts exactly 1 cycle per transition.
//    - Rise_o and Fall_o are never both 1 on the same bit.
//  - Debounce counter, per channel, width $clog2(DEBOUNCE_CYCLES+1):
//    - s == Sync_o: counter <= 0.
//    - s != Sync_o and counter < DEBOUNCE_CYCLES-1: counter increments.
//    - s != Sync_o and counter == DEBOUNCE_CYCLES-1: Sync_o <= s and counter <= 0.
//    - A return of s to Sync_o before that point clears the counter; Sync_o does not change and no pulse is emitted.
//    - Latency from capture edge to Sync_o change = STAGES+DEBOUNCE_CYCLES edges.
//    - With DEBOUNCE_CYCLES=1, latency is STAGES+1.
//    - The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
//  - Async_i toggling every cycle with debounce enabled: Sync_o holds its value indefinitely.
// CONFIGURATION
//  SYNCHRONIZER_DEBOUNCE_EN
//   - Defined: debounce counters are instantiated and Sync_o follows the debounce rules above.
//   - Undefined: counters are not instantiated. Sync_o = s, latency = STAGES, and DEBOUNCE_CYCLES is ignored.
//   - Chain and edge logic are identical in both builds.
// TESTING  (10 MHz Clock; WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4 unless stated)
//  1. Reset=1 for 2 cycles with Async_i=4'b1111
//     -> Sync_o=4'b0000, Rise_o=Fall_o=0 during reset and the first cycle after it.
//  2. No macro: Async_i 0000->0001 75 ns after an edge
//     -> Sync_o=0001 after the 2nd following edge and Rise_o=0001 for exactly 1 cycle.
//     Then 0001->0000 -> Fall_o=0001 for 1 cycle.
//  3. Macro: Async_i=0011 for 250 ns, then 0000 -> Sync_o stays 0000 and Rise_o/Fall_o stay 0.
//  4. Macro: Async_i=0011 held 1 us -> Sync_o=0011 exactly 6 edges after capture; Rise_o=0011 for a single cycle.
//  5. Macro: hold 0001 until the counter reaches 2, then Reset=1 for 1 cycle
//     -> Sync_o=0000, counter=0, no pulse; the change re-qualifies from 0.
//  6. STAGES=3, RESET_VALUE=4'b1010, Async_i held at 1010 through reset
//     -> Sync_o=1010 from reset onward, no edge pulses ever.

Source files
------------

// File: rtl/synchronizer_debouncer.sv
// Multi-channel CDC synchronizer with registered edge pulses and an optional per-channel
// debounce filter, enabled by defining SYNCHRONIZER_DEBOUNCE_EN.
module synchronizer_debouncer #(
   parameter int               WIDTH           = 4,
   parameter int               STAGES          = 2,
   parameter int               DEBOUNCE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Async_i,
   output logic [WIDTH-1:0] Sync_o,
   output logic [WIDTH-1:0] Rise_o,
   output logic [WIDTH-1:0] Fall_o
);

   logic [STAGES-1:0][WIDTH-1:0] stage_q;
   logic [WIDTH-1:0]             s;
   logic [WIDTH-1:0]             prev_q;

   // Async_i is sampled only by stage 0; every later stage sees a registered value.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         stage_q <= {STAGES{RESET_VALUE}};
      end else begin
         stage_q <= {stage_q[STAGES-2:0], Async_i};
      end
   end

   assign s = stage_q[STAGES-1];

`ifdef SYNCHRONIZER_DEBOUNCE_EN
   localparam int          CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]         sync_q, sync_d;

   always_comb begin
      cnt_d  = cnt_q;
      sync_d = sync_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (s[i] == sync_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            sync_d[i] = s[i];
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt_q  <= '0;
         sync_q <= RESET_VALUE;
      end else begin
         cnt_q  <= cnt_d;
         sync_q <= sync_d;
      end
   end

   assign Sync_o = sync_q;
`else
   assign Sync_o = s;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         prev_q <= RESET_VALUE;
      end else begin
         prev_q <= Sync_o;
      end
   end

   // Pulses decode registers only, so no combinational path from Async_i exists.
   assign Rise_o = Sync_o & ~prev_q;
   assign Fall_o = ~Sync_o & prev_q;

endmodule
